// File: rtl/stage_id_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_defs (package)
// Description : MIPS opcode/funct constants, EX operator/category codes and the
//               decode record shared by the ID stage and its decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_defs;

    localparam logic [5:0] c_OPC_SPECIAL = 6'h00;
    localparam logic [5:0] c_OPC_ANDI    = 6'h0c;
    localparam logic [5:0] c_OPC_ORI     = 6'h0d;
    localparam logic [5:0] c_OPC_XORI    = 6'h0e;
    localparam logic [5:0] c_OPC_LUI     = 6'h0f;

    localparam logic [5:0] c_FUNCT_AND   = 6'h24;
    localparam logic [5:0] c_FUNCT_OR    = 6'h25;
    localparam logic [5:0] c_FUNCT_XOR   = 6'h26;
    localparam logic [5:0] c_FUNCT_NOR   = 6'h27;

    localparam logic [7:0] c_OP_NOP      = 8'b00000000;
    localparam logic [7:0] c_OP_AND      = 8'b00100100;
    localparam logic [7:0] c_OP_OR       = 8'b00100101;
    localparam logic [7:0] c_OP_XOR      = 8'b00100110;
    localparam logic [7:0] c_OP_NOR      = 8'b00100111;

    localparam logic [2:0] c_CAT_NOP     = 3'b000;
    localparam logic [2:0] c_CAT_LOGIC   = 3'b001;

    localparam logic [4:0] c_REG_ZERO    = 5'd0;

    typedef struct packed {
        logic [7:0]  operator_code;
        logic [2:0]  category;
        logic        read_enable_a;
        logic [4:0]  read_address_a;
        logic        read_enable_b;
        logic [4:0]  read_address_b;
        logic [31:0] immediate;
        logic        write_enable;
        logic [4:0]  write_address;
    } decode_t;

    localparam decode_t c_DECODE_NOP = '0;

    function automatic logic [31:0] f_zero_extend16(input logic [15:0] value);
        return {16'h0000, value};
    endfunction

endpackage
`default_nettype wire

// File: rtl/stage_id_if.sv
`default_nettype none
// ============================================================================
// Module      : stage_id_if
// Description : ID-stage bus: pipeline control, IF/ID instruction, register
//               file read ports, EX/MEM write-back ports and ID/EX outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface stage_id_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      stall;
    logic                      flush;
    logic                      instruction_valid;
    logic [31:0]               instruction;

    logic                      register_read_enable_a;
    logic [REG_ADDR_WIDTH-1:0] register_read_address_a;
    logic [DATA_WIDTH-1:0]     register_read_data_a;
    logic                      register_read_enable_b;
    logic [REG_ADDR_WIDTH-1:0] register_read_address_b;
    logic [DATA_WIDTH-1:0]     register_read_data_b;

    logic                      ex_register_write_enable;
    logic [REG_ADDR_WIDTH-1:0] ex_register_write_address;
    logic [DATA_WIDTH-1:0]     ex_register_write_data;
    logic                      mem_register_write_enable;
    logic [REG_ADDR_WIDTH-1:0] mem_register_write_address;
    logic [DATA_WIDTH-1:0]     mem_register_write_data;

    logic [7:0]                operator;
    logic [2:0]                category;
    logic [DATA_WIDTH-1:0]     operand_a;
    logic [DATA_WIDTH-1:0]     operand_b;
    logic                      register_write_enable;
    logic [REG_ADDR_WIDTH-1:0] register_write_address;

    modport master (
        input  stall, flush, instruction_valid, instruction,
        input  register_read_data_a, register_read_data_b,
        input  ex_register_write_enable, ex_register_write_address, ex_register_write_data,
        input  mem_register_write_enable, mem_register_write_address, mem_register_write_data,
        output register_read_enable_a, register_read_address_a,
        output register_read_enable_b, register_read_address_b,
        output operator, category, operand_a, operand_b,
        output register_write_enable, register_write_address
    );

    modport slave (
        output stall, flush, instruction_valid, instruction,
        output register_read_data_a, register_read_data_b,
        output ex_register_write_enable, ex_register_write_address, ex_register_write_data,
        output mem_register_write_enable, mem_register_write_address, mem_register_write_data,
        input  register_read_enable_a, register_read_address_a,
        input  register_read_enable_b, register_read_address_b,
        input  operator, category, operand_a, operand_b,
        input  register_write_enable, register_write_address
    );

endinterface
`default_nettype wire

// File: rtl/stage_id_decoder.sv
`default_nettype none
// ============================================================================
// Module      : instruction_decoder
// Description : Combinational MIPS logic-subset decoder producing operator,
//               category, read requests, immediate and destination.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_decoder
    import cpu_defs::*;
(
    input  logic        i_instruction_valid,
    input  logic [31:0] i_instruction,
    output decode_t     o_decode
);

    logic [5:0]  w_opcode;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [5:0]  w_funct;
    logic [15:0] w_imm16;
    logic [7:0]  w_operator;
    logic        w_rtype;
    logic        w_lui;
    logic [4:0]  w_dest;

    assign w_opcode = i_instruction[31:26];
    assign w_rs     = i_instruction[25:21];
    assign w_rt     = i_instruction[20:16];
    assign w_rd     = i_instruction[15:11];
    assign w_funct  = i_instruction[5:0];
    assign w_imm16  = i_instruction[15:0];

    always_comb begin
        w_operator = c_OP_NOP;
        w_rtype    = 1'b0;
        w_lui      = 1'b0;
        case (w_opcode)
            c_OPC_SPECIAL: begin
                w_rtype = 1'b1;
                case (w_funct)
                    c_FUNCT_OR:  w_operator = c_OP_OR;
                    c_FUNCT_AND: w_operator = c_OP_AND;
                    c_FUNCT_XOR: w_operator = c_OP_XOR;
                    c_FUNCT_NOR: w_operator = c_OP_NOR;
                    default:     w_operator = c_OP_NOP;
                endcase
            end
            c_OPC_ORI:  w_operator = c_OP_OR;
            c_OPC_ANDI: w_operator = c_OP_AND;
            c_OPC_XORI: w_operator = c_OP_XOR;
            // LUI executes as OR of zero with the upper-shifted immediate
            c_OPC_LUI: begin
                w_operator = c_OP_OR;
                w_lui      = 1'b1;
            end
            default: w_operator = c_OP_NOP;
        endcase
    end

    assign w_dest = w_rtype ? w_rd : w_rt;

    always_comb begin
        o_decode = c_DECODE_NOP;
        if (i_instruction_valid && (w_operator != c_OP_NOP)) begin
            o_decode.operator_code  = w_operator;
            o_decode.category       = c_CAT_LOGIC;
            o_decode.read_enable_a  = !w_lui;
            o_decode.read_address_a = w_lui ? c_REG_ZERO : w_rs;
            o_decode.read_enable_b  = w_rtype;
            o_decode.read_address_b = w_rtype ? w_rt : c_REG_ZERO;
            if (w_rtype) begin
                o_decode.immediate = 32'h0000_0000;
            end else if (w_lui) begin
                o_decode.immediate = {w_imm16, 16'h0000};
            end else begin
                o_decode.immediate = f_zero_extend16(w_imm16);
            end
            o_decode.write_enable  = (w_dest != c_REG_ZERO);
            o_decode.write_address = w_dest;
        end
    end

endmodule
`default_nettype wire

// File: rtl/stage_id.sv
`default_nettype none
// ============================================================================
// Module      : stage_id
// Description : MIPS ID stage: decode, register-file read requests, operand
//               resolution and the ID/EX register with stall/flush control.
//               Define STAGE_ID_FORWARDING_EN to forward from EX/MEM ports.
// Revision    : 1.0 - initial release
// ============================================================================
module stage_id
    import cpu_defs::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic       clock,
    input  logic       reset,
    stage_id_if.master bus
);

    decode_t                   w_dec;
    logic [REG_ADDR_WIDTH-1:0] w_addr_a;
    logic [REG_ADDR_WIDTH-1:0] w_addr_b;
    logic [REG_ADDR_WIDTH-1:0] w_dest;
    logic [DATA_WIDTH-1:0]     w_imm;
    logic [DATA_WIDTH-1:0]     w_src_a;
    logic [DATA_WIDTH-1:0]     w_src_b;
    logic [DATA_WIDTH-1:0]     w_operand_a;
    logic [DATA_WIDTH-1:0]     w_operand_b;

    logic [7:0]                r_operator;
    logic [2:0]                r_category;
    logic [DATA_WIDTH-1:0]     r_operand_a;
    logic [DATA_WIDTH-1:0]     r_operand_b;
    logic                      r_write_enable;
    logic [REG_ADDR_WIDTH-1:0] r_write_address;

    instruction_decoder u_decoder (
        .i_instruction_valid (bus.instruction_valid),
        .i_instruction       (bus.instruction),
        .o_decode            (w_dec)
    );

    assign w_addr_a = REG_ADDR_WIDTH'(w_dec.read_address_a);
    assign w_addr_b = REG_ADDR_WIDTH'(w_dec.read_address_b);
    assign w_dest   = REG_ADDR_WIDTH'(w_dec.write_address);
    assign w_imm    = DATA_WIDTH'(w_dec.immediate);

    assign bus.register_read_enable_a  = w_dec.read_enable_a & ~reset;
    assign bus.register_read_address_a = w_addr_a;
    assign bus.register_read_enable_b  = w_dec.read_enable_b & ~reset;
    assign bus.register_read_address_b = w_addr_b;

    always_comb begin
        w_src_a = bus.register_read_data_a;
        w_src_b = bus.register_read_data_b;
`ifdef STAGE_ID_FORWARDING_EN
        // EX holds the younger result, so it wins over MEM
        if (bus.ex_register_write_enable && (bus.ex_register_write_address == w_addr_a)) begin
            w_src_a = bus.ex_register_write_data;
        end else if (bus.mem_register_write_enable && (bus.mem_register_write_address == w_addr_a)) begin
            w_src_a = bus.mem_register_write_data;
        end
        if (bus.ex_register_write_enable && (bus.ex_register_write_address == w_addr_b)) begin
            w_src_b = bus.ex_register_write_data;
        end else if (bus.mem_register_write_enable && (bus.mem_register_write_address == w_addr_b)) begin
            w_src_b = bus.mem_register_write_data;
        end
`endif
    end

    // $0 is hard-wired zero; disabled ports fall back to immediate or zero
    always_comb begin
        w_operand_a = '0;
        if (w_dec.read_enable_a && (w_addr_a != '0)) begin
            w_operand_a = w_src_a;
        end
        w_operand_b = w_imm;
        if (w_dec.read_enable_b) begin
            w_operand_b = (w_addr_b != '0) ? w_src_b : '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || bus.flush) begin
            r_operator      <= c_OP_NOP;
            r_category      <= c_CAT_NOP;
            r_operand_a     <= '0;
            r_operand_b     <= '0;
            r_write_enable  <= 1'b0;
            r_write_address <= '0;
        end else if (bus.stall) begin
            r_operator      <= r_operator;
            r_category      <= r_category;
            r_operand_a     <= r_operand_a;
            r_operand_b     <= r_operand_b;
            r_write_enable  <= r_write_enable;
            r_write_address <= r_write_address;
        end else if (bus.instruction_valid) begin
            r_operator      <= w_dec.operator_code;
            r_category      <= w_dec.category;
            r_operand_a     <= w_operand_a;
            r_operand_b     <= w_operand_b;
            r_write_enable  <= w_dec.write_enable;
            r_write_address <= w_dest;
        end else begin
            r_operator      <= c_OP_NOP;
            r_category      <= c_CAT_NOP;
            r_operand_a     <= '0;
            r_operand_b     <= '0;
            r_write_enable  <= 1'b0;
            r_write_address <= '0;
        end
    end

    assign bus.operator               = r_operator;
    assign bus.category               = r_category;
    assign bus.operand_a              = r_operand_a;
    assign bus.operand_b              = r_operand_b;
    assign bus.register_write_enable  = r_write_enable;
    assign bus.register_write_address = r_write_address;

endmodule
`default_nettype wire

// File: tb/tb_stage_id.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage_id
// Description : Directed vector bench for stage_id (optionally built with
//               STAGE_ID_FORWARDING_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_id;

`ifdef STAGE_ID_FORWARDING_EN
    localparam bit c_FWD = 1'b1;
`else
    localparam bit c_FWD = 1'b0;
`endif

    typedef struct {
        string       name;
        logic        stall, flush, valid;
        logic [31:0] instr, rda, rdb;
        logic        ex_we;  logic [4:0] ex_wa;  logic [31:0] ex_wd;
        logic        mem_we; logic [4:0] mem_wa; logic [31:0] mem_wd;
        logic        re_a;   logic [4:0] ra_a;
        logic        re_b;   logic [4:0] ra_b;
        logic [7:0]  op;     logic [2:0] cat;
        logic [31:0] opa, opb;
        logic        we;     logic [4:0] wa;
    } vec_t;

    logic clock;
    logic reset;
    int   n_vec;
    int   n_miss;
    vec_t tbl[$];
    vec_t t;

    stage_id_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

    stage_id #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input string name, input logic [31:0] instr, rda, rdb,
                                input logic re_a, input logic [4:0] ra_a,
                                input logic re_b, input logic [4:0] ra_b,
                                input logic [7:0] op, input logic [2:0] cat,
                                input logic [31:0] opa, opb,
                                input logic we, input logic [4:0] wa);
        vec_t v;
        v.name = name; v.stall = 1'b0; v.flush = 1'b0; v.valid = 1'b1;
        v.instr = instr; v.rda = rda; v.rdb = rdb;
        v.ex_we = 1'b0;  v.ex_wa = 5'd0;  v.ex_wd = 32'h0;
        v.mem_we = 1'b0; v.mem_wa = 5'd0; v.mem_wd = 32'h0;
        v.re_a = re_a; v.ra_a = ra_a; v.re_b = re_b; v.ra_b = ra_b;
        v.op = op; v.cat = cat; v.opa = opa; v.opb = opb; v.we = we; v.wa = wa;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_regs(input string tag, input logic [7:0] op, input logic [2:0] cat,
                              input logic [31:0] opa, opb, input logic we, input logic [4:0] wa);
        check({tag, ".operator"},  {24'h0, bus.operator}, {24'h0, op});
        check({tag, ".category"},  {29'h0, bus.category}, {29'h0, cat});
        check({tag, ".operand_a"}, bus.operand_a, opa);
        check({tag, ".operand_b"}, bus.operand_b, opb);
        check({tag, ".wr_en"},     {31'h0, bus.register_write_enable}, {31'h0, we});
        check({tag, ".wr_addr"},   {27'h0, bus.register_write_address}, {27'h0, wa});
    endtask

    task automatic drive(input vec_t v);
        bus.stall = v.stall; bus.flush = v.flush;
        bus.instruction_valid = v.valid; bus.instruction = v.instr;
        bus.register_read_data_a = v.rda; bus.register_read_data_b = v.rdb;
        bus.ex_register_write_enable = v.ex_we;
        bus.ex_register_write_address = v.ex_wa;
        bus.ex_register_write_data = v.ex_wd;
        bus.mem_register_write_enable = v.mem_we;
        bus.mem_register_write_address = v.mem_wa;
        bus.mem_register_write_data = v.mem_wd;
    endtask

    task automatic apply(input vec_t v);
        @(negedge clock);
        drive(v);
        #1;
        check({v.name, ".re_a"}, {31'h0, bus.register_read_enable_a}, {31'h0, v.re_a});
        check({v.name, ".ra_a"}, {27'h0, bus.register_read_address_a}, {27'h0, v.ra_a});
        check({v.name, ".re_b"}, {31'h0, bus.register_read_enable_b}, {31'h0, v.re_b});
        check({v.name, ".ra_b"}, {27'h0, bus.register_read_address_b}, {27'h0, v.ra_b});
        @(posedge clock);
        #1;
        check_regs(v.name, v.op, v.cat, v.opa, v.opb, v.we, v.wa);
        n_vec++;
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;

        tbl.push_back(mk("or_basic", 32'h00221825, 32'h0000F0F0, 32'h00000F0F, 1, 1, 1, 2, 8'h25, 1, 32'h0000F0F0, 32'h00000F0F, 1, 3));
        tbl.push_back(mk("and",      32'h00A62024, 32'hFFFF0000, 32'h12345678, 1, 5, 1, 6, 8'h24, 1, 32'hFFFF0000, 32'h12345678, 1, 4));
        tbl.push_back(mk("xor",      32'h00223826, 32'hAAAAAAAA, 32'h55555555, 1, 1, 1, 2, 8'h26, 1, 32'hAAAAAAAA, 32'h55555555, 1, 7));
        tbl.push_back(mk("nor",      32'h00224027, 32'h00000001, 32'h00000002, 1, 1, 1, 2, 8'h27, 1, 32'h00000001, 32'h00000002, 1, 8));
        tbl.push_back(mk("lui",      32'h3C05ABCD, 32'hDEADBEEF, 32'hCAFEF00D, 0, 0, 0, 0, 8'h25, 1, 32'h00000000, 32'hABCD0000, 1, 5));
        tbl.push_back(mk("andi",     32'h306200FF, 32'h0F0F0F0F, 32'hFFFFFFFF, 1, 3, 0, 0, 8'h24, 1, 32'h0F0F0F0F, 32'h000000FF, 1, 2));
        tbl.push_back(mk("xori",     32'h38298000, 32'h12340000, 32'h99999999, 1, 1, 0, 0, 8'h26, 1, 32'h12340000, 32'h00008000, 1, 9));
        tbl.push_back(mk("ori_rs0",  32'h34011100, 32'hDEADBEEF, 32'h0,        1, 0, 0, 0, 8'h25, 1, 32'h00000000, 32'h00001100, 1, 1));
        tbl.push_back(mk("or_rs0",   32'h00021825, 32'hDEADBEEF, 32'h00000F0F, 1, 0, 1, 2, 8'h25, 1, 32'h00000000, 32'h00000F0F, 1, 3));
        tbl.push_back(mk("or_rd0",   32'h00220025, 32'h0000F0F0, 32'h00000F0F, 1, 1, 1, 2, 8'h25, 1, 32'h0000F0F0, 32'h00000F0F, 0, 0));
        tbl.push_back(mk("undef_3f", 32'hFC000000, 32'h00000001, 32'h00000002, 0, 0, 0, 0, 8'h00, 0, 32'h0, 32'h0, 0, 0));
        tbl.push_back(mk("bad_funct",32'h00221820, 32'h00000001, 32'h00000002, 0, 0, 0, 0, 8'h00, 0, 32'h0, 32'h0, 0, 0));
        t = mk("invalid", 32'h00221825, 32'h11, 32'h22, 0, 0, 0, 0, 8'h00, 0, 32'h0, 32'h0, 0, 0);
        t.valid = 1'b0; tbl.push_back(t);

        // stall holds the AND result while a XOR sits at the input
        tbl.push_back(mk("load_and", 32'h00A62024, 32'hFFFF0000, 32'h12345678, 1, 5, 1, 6, 8'h24, 1, 32'hFFFF0000, 32'h12345678, 1, 4));
        for (int i = 0; i < 2; i++) begin
            t = mk("stall", 32'h00223826, 32'hAAAAAAAA, 32'h55555555, 1, 1, 1, 2, 8'h24, 1, 32'hFFFF0000, 32'h12345678, 1, 4);
            t.stall = 1'b1; tbl.push_back(t);
        end
        t = mk("stall_flush", 32'h00223826, 32'hAAAAAAAA, 32'h55555555, 1, 1, 1, 2, 8'h00, 0, 32'h0, 32'h0, 0, 0);
        t.stall = 1'b1; t.flush = 1'b1; tbl.push_back(t);
        tbl.push_back(mk("reload_or", 32'h00221825, 32'h0000F0F0, 32'h00000F0F, 1, 1, 1, 2, 8'h25, 1, 32'h0000F0F0, 32'h00000F0F, 1, 3));
        t = mk("flush", 32'h00A62024, 32'hFFFF0000, 32'h12345678, 1, 5, 1, 6, 8'h00, 0, 32'h0, 32'h0, 0, 0);
        t.flush = 1'b1; tbl.push_back(t);

        t = mk("fwd_ex_mem", 32'h00221825, 32'hAAAA0000, 32'h0000BBBB, 1, 1, 1, 2, 8'h25, 1,
               c_FWD ? 32'h11111111 : 32'hAAAA0000, 32'h0000BBBB, 1, 3);
        t.ex_we = 1; t.ex_wa = 1; t.ex_wd = 32'h11111111;
        t.mem_we = 1; t.mem_wa = 1; t.mem_wd = 32'h22222222; tbl.push_back(t);
        t = mk("fwd_mem_b", 32'h00221825, 32'h01010101, 32'h02020202, 1, 1, 1, 2, 8'h25, 1,
               32'h01010101, c_FWD ? 32'h33333333 : 32'h02020202, 1, 3);
        t.ex_we = 1; t.ex_wa = 5; t.ex_wd = 32'h55555555;
        t.mem_we = 1; t.mem_wa = 2; t.mem_wd = 32'h33333333; tbl.push_back(t);
        t = mk("fwd_reg0", 32'h00021825, 32'hDEADBEEF, 32'h44444444, 1, 0, 1, 2, 8'h25, 1, 32'h0, 32'h44444444, 1, 3);
        t.ex_we = 1; t.ex_wa = 0; t.ex_wd = 32'h77777777; tbl.push_back(t);
        t = mk("fwd_we_off", 32'h00221825, 32'h0000F0F0, 32'h00000F0F, 1, 1, 1, 2, 8'h25, 1, 32'h0000F0F0, 32'h00000F0F, 1, 3);
        t.ex_we = 0; t.ex_wa = 1; t.ex_wd = 32'h66666666; tbl.push_back(t);
        t = mk("fwd_andi", 32'h306200FF, 32'h0F0F0F0F, 32'hFFFFFFFF, 1, 3, 0, 0, 8'h24, 1,
               c_FWD ? 32'h88888888 : 32'h0F0F0F0F, 32'h000000FF, 1, 2);
        t.mem_we = 1; t.mem_wa = 3; t.mem_wd = 32'h88888888; tbl.push_back(t);

        // reset held 3 cycles with ORI $1,$0,0x1100 presented
        reset = 1'b1;
        drive(mk("rst", 32'h34011100, 32'h12345678, 32'h9ABCDEF0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            check_regs("reset", 8'h00, 3'd0, 32'h0, 32'h0, 1'b0, 5'd0);
            check("reset.re_a", {31'h0, bus.register_read_enable_a}, 32'h0);
            check("reset.re_b", {31'h0, bus.register_read_enable_b}, 32'h0);
            n_vec++;
        end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check_regs("post_reset", 8'h25, 3'd1, 32'h0, 32'h00001100, 1'b1, 5'd1);
        n_vec++;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        // reset asserted mid-stream clears a loaded result
        apply(tbl[0]);
        @(negedge clock);
        reset = 1'b1;
        drive(tbl[1]);
        #1;
        check("midrst.re_a", {31'h0, bus.register_read_enable_a}, 32'h0);
        check("midrst.re_b", {31'h0, bus.register_read_enable_b}, 32'h0);
        @(posedge clock);
        #1;
        check_regs("midrst", 8'h00, 3'd0, 32'h0, 32'h0, 1'b0, 5'd0);
        n_vec++;
        @(negedge clock);
        reset = 1'b0;
        apply(tbl[2]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
